// File: rtl/mbus_mem_responder.sv
// Memory-side mbus responder: in-order read returns after a fixed pipeline latency,
// byte-strobed writes with queued write responses, and out-of-range address detection.
module mbus_mem_responder #(
    parameter int MBUS_DATA_WIDTH = 32,
    parameter int MBUS_ADDR_WIDTH = 32,
    parameter int MEM_DEPTH_BITS  = 10,
    parameter int READ_LATENCY    = 2,
    parameter int OUTST_BITS      = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [MBUS_ADDR_WIDTH-1:0]   mbus_ar_addr,
    input  logic                         mbus_ar_valid,
    output logic                         mbus_ar_ready,
    output logic [MBUS_DATA_WIDTH-1:0]   mbus_r_data,
    output logic                         mbus_r_valid,
    input  logic                         mbus_r_ready,
    input  logic [MBUS_ADDR_WIDTH-1:0]   mbus_aw_addr,
    input  logic                         mbus_aw_valid,
    output logic                         mbus_aw_ready,
    input  logic [MBUS_DATA_WIDTH-1:0]   mbus_w_data,
    input  logic                         mbus_w_valid,
    input  logic [MBUS_DATA_WIDTH/8-1:0] mbus_w_strb,
    output logic                         mbus_b_resp,
    output logic                         mbus_b_valid,
    input  logic                         mbus_b_ready
);

    localparam int WORDS  = 1 << MEM_DEPTH_BITS;
    localparam int QDEPTH = 1 << OUTST_BITS;
    localparam int STRB_W = MBUS_DATA_WIDTH / 8;
    localparam logic [OUTST_BITS:0] QFULL = QDEPTH[OUTST_BITS:0];

    // Storage has no reset so its contents survive a reset pulse.
    logic [MBUS_DATA_WIDTH-1:0] mem [WORDS];

    logic                       run;
    logic [OUTST_BITS:0]        rd_outstanding;
    logic [OUTST_BITS:0]        rf_count;
    logic [OUTST_BITS:0]        b_count;
    logic [READ_LATENCY-1:0]    pipe_valid;
    logic [MBUS_DATA_WIDTH-1:0] pipe_data [READ_LATENCY];
    logic [MBUS_DATA_WIDTH-1:0] rf_data [QDEPTH];
    logic [OUTST_BITS-1:0]      rf_wptr;
    logic [OUTST_BITS-1:0]      rf_rptr;
    logic [QDEPTH-1:0]          b_fifo;
    logic [OUTST_BITS-1:0]      b_wptr;
    logic [OUTST_BITS-1:0]      b_rptr;

    logic                       ar_oor;
    logic                       aw_oor;
    logic [MEM_DEPTH_BITS-1:0]  ar_idx;
    logic [MEM_DEPTH_BITS-1:0]  aw_idx;
    logic [MBUS_DATA_WIDTH-1:0] rd_word;
    logic                       ar_fire;
    logic                       r_fire;
    logic                       aw_fire;
    logic                       b_fire;
    logic                       rf_push;
    logic                       unused_addr_lsbs;

    assign unused_addr_lsbs = ^{mbus_ar_addr[1:0], mbus_aw_addr[1:0]};

    assign ar_oor  = |mbus_ar_addr[MBUS_ADDR_WIDTH-1:MEM_DEPTH_BITS+2];
    assign aw_oor  = |mbus_aw_addr[MBUS_ADDR_WIDTH-1:MEM_DEPTH_BITS+2];
    assign ar_idx  = mbus_ar_addr[MEM_DEPTH_BITS+1:2];
    assign aw_idx  = mbus_aw_addr[MEM_DEPTH_BITS+1:2];
    // Read samples storage before this cycle's write lands, giving read-before-write.
    assign rd_word = ar_oor ? '0 : mem[ar_idx];

    // Handshakes: a transfer happens on a clock edge where valid && ready are both high;
    // ready depends only on registered counts, and a held valid keeps its payload stable.
    // A write needs aw_valid and w_valid together; either one alone is not a transfer.
    assign mbus_ar_ready = run && (rd_outstanding < QFULL);
    assign mbus_aw_ready = run && (b_count < QFULL);
    assign mbus_r_valid  = (rf_count != '0);
    assign mbus_r_data   = mbus_r_valid ? rf_data[rf_rptr] : '0;
    assign mbus_b_valid  = (b_count != '0);
    assign mbus_b_resp   = mbus_b_valid && b_fifo[b_rptr];

    assign ar_fire = mbus_ar_valid && mbus_ar_ready;
    assign r_fire  = mbus_r_valid && mbus_r_ready;
    assign aw_fire = mbus_aw_valid && mbus_w_valid && mbus_aw_ready;
    assign b_fire  = mbus_b_valid && mbus_b_ready;
    assign rf_push = pipe_valid[READ_LATENCY-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run            <= 1'b0;
            rd_outstanding <= '0;
            rf_count       <= '0;
            rf_wptr        <= '0;
            rf_rptr        <= '0;
            b_count        <= '0;
            b_wptr         <= '0;
            b_rptr         <= '0;
            pipe_valid     <= '0;
        end else begin
            run           <= 1'b1;
            pipe_valid[0] <= ar_fire;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
            end

            if (ar_fire && !r_fire) begin
                rd_outstanding <= rd_outstanding + 1'b1;
            end else if (!ar_fire && r_fire) begin
                rd_outstanding <= rd_outstanding - 1'b1;
            end

            // The outstanding limit guarantees the return FIFO never overflows.
            if (rf_push) begin
                rf_wptr <= rf_wptr + 1'b1;
            end
            if (r_fire) begin
                rf_rptr <= rf_rptr + 1'b1;
            end
            if (rf_push && !r_fire) begin
                rf_count <= rf_count + 1'b1;
            end else if (!rf_push && r_fire) begin
                rf_count <= rf_count - 1'b1;
            end

            if (aw_fire) begin
                b_wptr <= b_wptr + 1'b1;
            end
            if (b_fire) begin
                b_rptr <= b_rptr + 1'b1;
            end
            if (aw_fire && !b_fire) begin
                b_count <= b_count + 1'b1;
            end else if (!aw_fire && b_fire) begin
                b_count <= b_count - 1'b1;
            end
        end
    end

    // Payload registers carry no reset; the valid bits above qualify them.
    always_ff @(posedge clk) begin
        pipe_data[0] <= rd_word;
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_data[i] <= pipe_data[i-1];
        end
        if (rf_push) begin
            rf_data[rf_wptr] <= pipe_data[READ_LATENCY-1];
        end
        if (aw_fire) begin
            b_fifo[b_wptr] <= aw_oor;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && aw_fire && !aw_oor) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (mbus_w_strb[i]) begin
                    mem[aw_idx][8*i +: 8] <= mbus_w_data[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: doc/mbus_mem_responder.md
Name: mbus_mem_responder

Overview:
Memory-side responder for the mbus read/write channels that the vector unit's memory queue drives as initiator. It accepts read addresses and returns data in order after a fixed pipeline latency, and accepts write address and data with byte strobes and returns write responses. It replaces the fixed-behaviour mock memory as the bench and FPGA-test memory endpoint. It provides bounded outstanding-transaction queues and out-of-range error reporting.

Parameters:
MBUS_DATA_WIDTH, 32, data width in bits; must be 32.
MBUS_ADDR_WIDTH, 32, byte address width.
MEM_DEPTH_BITS, 10, log2 of the storage word count.
READ_LATENCY, 2, cycles from AR accept to the earliest r_valid; must be 1 to 4.
OUTST_BITS, 2, log2 of the maximum outstanding reads and, separately, outstanding write responses.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
mbus_ar_addr  in  MBUS_ADDR_WIDTH  read byte address
mbus_ar_valid  in  1  read address valid
mbus_ar_ready  out  1  read address accepted
mbus_r_data  out  MBUS_DATA_WIDTH  read data
mbus_r_valid  out  1  read data valid
mbus_r_ready  in  1  initiator accepts read data
mbus_aw_addr  in  MBUS_ADDR_WIDTH  write byte address
mbus_aw_valid  in  1  write address valid
mbus_aw_ready  out  1  write address+data accepted
mbus_w_data  in  MBUS_DATA_WIDTH  write data
mbus_w_valid  in  1  write data valid
mbus_w_strb  in  MBUS_DATA_WIDTH/8  byte enables
mbus_b_resp  out  1  0 = OKAY, 1 = address error
mbus_b_valid  out  1  write response valid
mbus_b_ready  in  1  initiator accepts response

Behaviour:
- Reset (rst_n low at a clk edge): all outputs 0 the following cycle; read pipeline, read return FIFO, B FIFO and counters are cleared. Storage contents are retained.
- Reset mid-operation: in-flight reads and pending B responses are discarded. No r_valid or b_valid pulse follows reset release until a new accept.
- Addressing: word index = addr[MEM_DEPTH_BITS+1:2]; addr[1:0] are ignored. Out-of-range means any bit of addr above MEM_DEPTH_BITS+1 is set.
- Read accept: fires when ar_valid && ar_ready.
  - ar_ready = (rd_outstanding < 2**OUTST_BITS).
  - rd_outstanding counts reads that are accepted, in the pipeline, or in the return FIFO.
  - ar_ready is computed from the count only, with no same-cycle pop bypass.
  - Simultaneous accept and pop leave the count unchanged.
- Read data: storage is read in the accept cycle and delayed through a READ_LATENCY-stage valid/data shift pipeline into a 2**OUTST_BITS-entry return FIFO.
  - A read accepted at edge T gives mbus_r_valid = 1 no earlier than READ_LATENCY cycles after T, exactly then if the FIFO is empty.
  - mbus_r_data is the FIFO head. The head pops on r_valid && r_ready.
  - Responses are strictly in accept order. A held r_ready=0 holds r_valid and r_data stable.
  - Out-of-range reads return 0; there is no read error signal.
- Write accept: fires when aw_valid && w_valid && aw_ready.
  - aw_valid without w_valid is not accepted; w_valid alone is ignored.
  - aw_ready = (b_count < 2**OUTST_BITS), from the count only.
  - On accept, each byte i with w_strb[i]=1 is written at the next edge. Out-of-range writes do not modify storage.
- Write response: an accept pushes resp (1 if out-of-range, else 0) into the B FIFO. b_valid is asserted the cycle after accept at the earliest.
  - Pop on b_valid && b_ready; b_resp is the FIFO head.
  - Simultaneous push and pop keep b_count.
- Ordering and hazards:
  - A read and a write to the same word accepted in the same cycle: the read returns pre-write data.
  - A read accepted in any later cycle sees the write.
  - The read and write paths are otherwise independent and may accept in the same cycle.
- Full boundary: with 2**OUTST_BITS reads outstanding, ar_ready = 0 until a pop. It re-asserts in the cycle after the pop edge.

Test Plan:
- Reset then single write/read: write addr 0x10, data 0xDEADBEEF, strb 0xF -> b_valid one cycle later with b_resp = 0. Read 0x10 -> r_valid exactly 2 cycles after accept with r_data 0xDEADBEEF. Read 0x13 returns the same word.
- Byte strobes: write 0x20 = 0x11223344 with strb 0xF, then 0xAABBCCDD with strb 0x5 -> read 0x20 returns 0x11BB33DD.
- Backpressure and outstanding limit: r_ready held 0; issue 5 reads to 0x0, 0x4, 0x8, 0xC, 0x10 -> first 4 accepted, ar_ready = 0 for the 5th. Raise r_ready -> data returns in issue order and the 5th read is accepted after the first pop.
- Out-of-range: write addr 0x00001000 (MEM_DEPTH_BITS=10) -> b_resp = 1 and storage unchanged. Read 0x00001000 -> r_data = 0. Read 0x0 -> returns the prior value.
- Same-cycle hazard: word 0x40 holds 0x5; same-cycle read 0x40 and write 0x40 = 0x9 -> read returns 0x5 and the next read returns 0x9.
- Reset mid-flight: 3 reads and 2 writes accepted with r_ready = b_ready = 0, then rst_n = 0 for 1 cycle -> no r_valid or b_valid afterwards, ar_ready and aw_ready = 1, and previously written data is still readable.
